dct_block_sched: RTL and testbench

- Sequencing controller for the eight-point DCT coefficient units (z0..z7).
- Gathers a serial stream of signed 8-bit EEG samples into 8-sample blocks and presents each block in parallel to the coefficient units.
- Drives their enable and ROM chip-select for a fixed compute window, captures all eight 19-bit coefficients, and streams them out serially over a valid/ready handshake.
- Sits between the sample front-end and the compression packer.

---
 rtl/dct_block_sched.sv | 120 ++++++++++++
 tb/tb_dct_block_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_sched.sv
// dct_block_sched: gathers eight signed samples into a block and holds it on
// dct_in. It enables the coefficient units for DCT_LATENCY cycles, captures
// z0..z7, and then streams the coefficients out one at a time.
//
// Handshake: a transfer happens on every rising edge where valid && ready.
// A source that has raised valid keeps valid and its payload stable until
// that transfer happens. in_valid/in_ready and out_valid/out_ready follow
// this rule.
module dct_block_sched #(
    parameter int DCT_LATENCY = 10,  // legal range 1..63 (6-bit window timer)
    parameter int SAMPLE_W    = 8,
    parameter int COEF_W      = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   in_data,
    output logic                  in_ready,
    output logic [8*SAMPLE_W-1:0] dct_in,
    output logic                  dct_en,
    output logic                  dct_cs,
    input  logic [8*COEF_W-1:0]   dct_coefs,
    output logic                  out_valid,
    output logic [COEF_W-1:0]     out_data,
    output logic [2:0]            out_idx,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [5:0] TIMER_LAST = 6'(DCT_LATENCY - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          cnt;     // next sample slot to fill
    logic [5:0]          timer;   // position inside the compute window
    logic [2:0]          idx;     // coefficient being offered downstream
    logic                armed;   // low for the first cycle after reset
    logic [COEF_W-1:0]   coef_buf [8];
    logic                accept;
    logic                emit;

    // accept is derived from state directly so it does not loop through in_ready
    assign accept   = in_valid && armed && (state == LOAD);
    assign emit     = out_valid && out_ready;
    assign out_idx  = idx;
    assign out_last = out_valid && (idx == 3'd7);
    assign out_data = out_valid ? coef_buf[idx] : '0;

    // Next-state and per-state strobes; every output defaults to idle first
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dct_en    = 1'b0;
        dct_cs    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                busy     = 1'b0;
                in_ready = armed;
                if (accept && cnt == 3'd7) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                dct_en = 1'b1;
                dct_cs = 1'b1;
                if (timer == TIMER_LAST) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && idx == 3'd7) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State, sample slots, window timer and drain index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= LOAD;
            cnt    <= 3'd0;
            timer  <= 6'd0;
            idx    <= 3'd0;
            armed  <= 1'b0;
            dct_in <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                // cnt wraps 7 -> 0 on the eighth sample, ready for the next block
                dct_in[int'(cnt)*SAMPLE_W +: SAMPLE_W] <= in_data;
                cnt <= cnt + 3'd1;
            end
            if (state == COMPUTE && timer != TIMER_LAST) timer <= timer + 6'd1;
            else                                         timer <= 6'd0;
            if (state == CAPTURE) idx <= 3'd0;
            else if (emit)        idx <= idx + 3'd1;
        end
    end

    // Coefficient buffer is loaded once per block; out_data is gated so it needs no reset
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int k = 0; k < 8; k++) begin
                coef_buf[k] <= dct_coefs[k*COEF_W +: COEF_W];
            end
        end
    end

endmodule

// File: tb/tb_dct_block_sched.sv
// tb_dct_block_sched: directed bench for dct_block_sched with a scoreboard.
// The coefficient units are a model that presents valid z0..z7 only once
// dct_en has been high for exactly LAT consecutive cycles.
module tb_dct_block_sched;

    localparam int LAT = 10;
    localparam int SW  = 8;
    localparam int CW  = 19;
    localparam int EW  = CW + 4;  // {idx, last, data}
    localparam logic [CW-1:0] GARB = 19'h2AAAA;

    // clock / reset
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main DUT signals
    logic            in_valid;
    logic [SW-1:0]   in_data;
    logic            in_ready;
    logic [8*SW-1:0] dct_in;
    logic            dct_en;
    logic            dct_cs;
    logic [8*CW-1:0] dct_coefs;
    logic            out_valid;
    logic [CW-1:0]   out_data;
    logic [2:0]      out_idx;
    logic            out_last;
    logic            out_ready;
    logic            busy;

    // latency sweep DUT signals
    logic            sw_valid;
    logic [SW-1:0]   sw_data;
    logic            sw_oready;
    logic            s1_in_ready, s1_en, s1_cs, s1_ov, s1_ol, s1_busy;
    logic [8*SW-1:0] s1_dct_in;
    logic [8*CW-1:0] s1_coefs;
    logic [CW-1:0]   s1_od;
    logic [2:0]      s1_oi;
    logic            s63_in_ready, s63_en, s63_cs, s63_ov, s63_ol, s63_busy;
    logic [8*SW-1:0] s63_dct_in;
    logic [8*CW-1:0] s63_coefs;
    logic [CW-1:0]   s63_od;
    logic [2:0]      s63_oi;

    dct_block_sched #(.DCT_LATENCY(LAT), .SAMPLE_W(SW), .COEF_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dct_in(dct_in), .dct_en(dct_en), .dct_cs(dct_cs),
        .dct_coefs(dct_coefs), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    dct_block_sched #(.DCT_LATENCY(1), .SAMPLE_W(SW), .COEF_W(CW)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_data(sw_data),
        .in_ready(s1_in_ready), .dct_in(s1_dct_in), .dct_en(s1_en), .dct_cs(s1_cs),
        .dct_coefs(s1_coefs), .out_valid(s1_ov), .out_data(s1_od),
        .out_idx(s1_oi), .out_last(s1_ol), .out_ready(sw_oready), .busy(s1_busy)
    );

    dct_block_sched #(.DCT_LATENCY(63), .SAMPLE_W(SW), .COEF_W(CW)) dut_lat63 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_data(sw_data),
        .in_ready(s63_in_ready), .dct_in(s63_dct_in), .dct_en(s63_en), .dct_cs(s63_cs),
        .dct_coefs(s63_coefs), .out_valid(s63_ov), .out_data(s63_od),
        .out_idx(s63_oi), .out_last(s63_ol), .out_ready(sw_oready), .busy(s63_busy)
    );

    // coefficient model: full-scale samples map to the 19-bit extremes
    function automatic logic [CW-1:0] coef_of(input logic [SW-1:0] s, input int k);
        int t;
        if (s == 8'h80) return 19'h40000;
        if (s == 8'h7F) return 19'h3FFFF;
        t = int'($signed(s)) * 1000 + k * 7;
        return t[CW-1:0];
    endfunction

    function automatic logic [8*CW-1:0] model_coefs(input logic [8*SW-1:0] b);
        logic [8*CW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*CW +: CW] = coef_of(b[k*SW +: SW], k);
        return r;
    endfunction

    assign s1_coefs  = model_coefs(s1_dct_in);
    assign s63_coefs = model_coefs(s63_dct_in);

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input logic [8*SW-1:0] b, input bit bubbles);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = b[k*SW +: SW];
            cyc_wait(1);
            if (bubbles) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                cyc_wait(1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || !in_ready) && n < 400) begin
            cyc_wait(1);
            n++;
        end
        chk(tag, n < 400, 1'b1);
    endtask

    task automatic wait_idx(input logic [2:0] i, input string tag);
        int n;
        n = 0;
        while (!(out_valid && out_idx == i) && n < 200) begin
            cyc_wait(1);
            n++;
        end
        chk(tag, n < 200, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1'b0);
        chk({tag, "_dct_en"},    dct_en,    1'b0);
        chk({tag, "_dct_cs"},    dct_cs,    1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"},  out_last,  1'b0);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_out_idx"},   out_idx,   3'd0);
        chk({tag, "_out_data"},  out_data,  19'd0);
        chk({tag, "_dct_in"},    dct_in,    64'd0);
    endtask

    function automatic logic [8*SW-1:0] rand_block();
        logic [8*SW-1:0] b;
        for (int k = 0; k < 8; k++) b[k*SW +: SW] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // monitor: drives the coefficient model and checks outputs on the falling edge
    initial begin
        int cyc, last_acc_cyc, acc_n, en_run, blk_emit;
        logic [8*SW-1:0] blk_acc, exp_blk;
        logic prev_en, prev_ov, prev_stall;
        logic [EW:0] prev_out;
        logic [EW-1:0] e;
        cyc = 0; last_acc_cyc = -100; acc_n = 0; en_run = 0; blk_emit = 0;
        blk_acc = '0; exp_blk = '0; prev_en = 1'b0; prev_ov = 1'b0; prev_stall = 1'b0;
        prev_out = '0;
        dct_coefs = {8{GARB}};
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                acc_n = 0; en_run = 0;
                prev_en = 1'b0; prev_ov = 1'b0; prev_stall = 1'b0;
                dct_coefs = {8{GARB}};
            end else begin
                if (dct_en) begin
                    en_run = prev_en ? en_run + 1 : 1;
                    dct_coefs = {8{GARB}};
                end else begin
                    dct_coefs = (en_run == LAT) ? model_coefs(dct_in) : {8{GARB}};
                end
                if (dct_en && !prev_en) begin
                    chk("compute_start", cyc, last_acc_cyc + 1);
                    chk("dct_in_block", dct_in, exp_blk);
                    blk_emit = 0;
                end
                if (!dct_en && prev_en) chk("dct_en_len", en_run, LAT);
                chk("cs_tracks_en", dct_cs, dct_en);
                chk("in_ready_excl", in_ready && (dct_en || out_valid), 1'b0);
                if (dct_en || out_valid) chk("busy_active", busy, 1'b1);
                if (out_valid && !prev_ov) chk("first_valid_lat", cyc - last_acc_cyc, LAT + 2);
                if (prev_stall) chk("hold_stable", {out_valid, out_idx, out_last, out_data}, prev_out);
                if (out_valid && out_ready) begin
                    chk("coef_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("coef", {out_idx, out_last, out_data}, e);
                    end
                    blk_emit++;
                    if (out_last) chk("coefs_per_block", blk_emit, 8);
                end
                if (in_valid && in_ready) begin
                    blk_acc[acc_n*SW +: SW] = in_data;
                    acc_n++;
                    if (acc_n == 8) begin
                        acc_n = 0;
                        last_acc_cyc = cyc;
                        exp_blk = blk_acc;
                        for (int k = 0; k < 8; k++)
                            exp_q.push_back({3'(k), (k == 7), coef_of(blk_acc[k*SW +: SW], k)});
                    end
                end
                prev_en    = dct_en;
                prev_ov    = out_valid;
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_valid, out_idx, out_last, out_data};
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // directed steps
    initial begin
        logic [8*SW-1:0] b;
        logic [CW-1:0] d0, d63_first;
        int en1, en63, f1, f63, n1, n63, cs_bad;
        logic [2:0] last1, last63;
        en1 = 0; en63 = 0; f1 = 0; f63 = 0; n1 = 0; n63 = 0; cs_bad = 0;
        last1 = 3'd0; last63 = 3'd0; d63_first = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_data = '0; sw_oready = 1'b1;

        // reset
        cyc_wait(3);
        chk_reset("rst");
        rst_n = 1'b1;
        cyc_wait(1);
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("busy_idle", busy, 1'b0);

        // basic block
        feed(64'h0807060504030201, 1'b0);
        cyc_wait(2);
        chk("dct_in_basic", dct_in, 64'h0807060504030201);
        chk("dct_en_basic", dct_en, 1'b1);
        wait_idle("idle_basic");
        chk("queue_empty_basic", exp_q.size(), 0);

        // signed extremes
        feed(64'h00FF7F8000FF7F80, 1'b0);
        wait_idx(3'd0, "wait_extremes");
        chk("signed_min_coef", out_data, 19'h40000);
        cyc_wait(1);
        chk("signed_max_coef", out_data, 19'h3FFFF);
        wait_idle("idle_extremes");

        // backpressure at idx 3
        feed(rand_block(), 1'b0);
        wait_idx(3'd3, "wait_bp");
        out_ready = 1'b0;
        d0 = out_data;
        for (int i = 0; i < 5; i++) begin
            cyc_wait(1);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_idx", out_idx, 3'd3);
            chk("bp_data", out_data, d0);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        wait_idle("idle_bp");
        chk("queue_empty_bp", exp_q.size(), 0);

        // input bubbles
        feed(rand_block(), 1'b1);
        wait_idle("idle_bubbles");

        // reset during COMPUTE cycle 4
        feed(rand_block(), 1'b0);
        cyc_wait(3);
        rst_n = 1'b0;
        cyc_wait(1);
        chk_reset("rst_compute");
        rst_n = 1'b1;
        cyc_wait(1);
        chk("in_ready_after_abort", in_ready, 1'b1);
        cyc_wait(20);

        // reset during DRAIN at idx 5
        feed(rand_block(), 1'b0);
        wait_idx(3'd5, "wait_idx5");
        rst_n = 1'b0;
        cyc_wait(1);
        chk_reset("rst_drain");
        rst_n = 1'b1;
        cyc_wait(20);
        chk("no_valid_after_reset", out_valid, 1'b0);

        // fresh block after aborts
        feed(rand_block(), 1'b0);
        wait_idle("idle_fresh");
        chk("queue_empty_fresh", exp_q.size(), 0);

        // latency sweep: DCT_LATENCY = 1 and 63 side by side
        b = rand_block();
        for (int k = 0; k < 8; k++) begin
            sw_valid = 1'b1;
            sw_data  = b[k*SW +: SW];
            cyc_wait(1);
        end
        sw_valid = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (s1_en) en1++;
            if (s63_en) en63++;
            if (s1_cs !== s1_en || s63_cs !== s63_en) cs_bad++;
            if (s1_ov && f1 == 0) f1 = k;
            if (s63_ov && f63 == 0) begin
                f63 = k;
                d63_first = s63_od;
            end
            if (s1_ov && sw_oready) begin
                n1++;
                if (s1_ol) last1 = s1_oi;
            end
            if (s63_ov && sw_oready) begin
                n63++;
                if (s63_ol) last63 = s63_oi;
            end
        end
        chk("lat1_en_len", en1, 1);
        chk("lat63_en_len", en63, 63);
        chk("lat1_first_valid", f1, 3);
        chk("lat63_first_valid", f63, 65);
        chk("lat1_emits", n1, 8);
        chk("lat63_emits", n63, 8);
        chk("sweep_cs_tracks_en", cs_bad, 0);
        chk("lat1_last_idx", last1, 3'd7);
        chk("lat63_last_idx", last63, 3'd7);
        chk("lat63_coef0", d63_first, coef_of(b[7:0], 0));
        chk("sweep_idle", {s1_in_ready, s1_busy, s63_in_ready, s63_busy}, 4'b1010);

        chk("queue_empty_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
